// File: rtl/clk_meter_pkg.sv
// -----------------------------------------------------------------------------
// clk_meter_pkg
// Shared definitions for the clock period meter:
//   - DEFAULT_WIDTH   : default width of the period/high-time counters
//   - DEFAULT_TIMEOUT : default clkIn cycles without a clkDiv edge that count
//                       as loss of clock
//   - meter_state_e   : measurement FSM state encoding (IDLE, MEASURE)
// -----------------------------------------------------------------------------
package clk_meter_pkg;

  localparam int DEFAULT_WIDTH   = 16;
  localparam int DEFAULT_TIMEOUT = 60000;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,  // waiting for the first clkDiv rising edge
    MEASURE = 1'b1   // counting between consecutive rising edges
  } meter_state_e;

endpackage : clk_meter_pkg

// File: rtl/edge_sync.sv
// -----------------------------------------------------------------------------
// edge_sync
// Two-flop synchronizer plus rising-edge detector for an asynchronous input.
// Ports:
//   clkIn  in   sampling clock
//   reset  in   asynchronous active-high reset
//   din    in   asynchronous input
//   level  out  synchronized level, delayed one cycle behind the detector so
//               it is 0 in the cycle a rise is reported
//   rise   out  one-cycle pulse: synchronized value is 1, previous sample 0
// A change on din is seen on rise three clkIn edges later (two sync flops,
// then acted on at the third edge).
// -----------------------------------------------------------------------------
module edge_sync (
  input  logic clkIn,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the clock edge, giving a true shift register.
  always_ff @(posedge clkIn or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise  = sync2_q & ~prev_q;
  // prev_q is high for exactly as many cycles as din was high, starting the
  // cycle after the rise; counting it makes highTime equal the high duration.
  assign level = prev_q;

endmodule : edge_sync

// File: rtl/clk_period_meter.sv
// -----------------------------------------------------------------------------
// clk_period_meter
// Measures the period and high time of clkDiv in clkIn cycles.
// Parameters:
//   WIDTH    counter/output width (default 16)
//   TIMEOUT  clkIn cycles without an edge that flag loss of clock
// Ports:
//   clkIn        in   system clock, all logic on its rising edge
//   reset        in   asynchronous active-high reset
//   clkDiv       in   clock under measurement, asynchronous to clkIn
//   period       out  last measured period (clkIn cycles)
//   highTime     out  clkIn cycles clkDiv was high in that period
//   periodValid  out  one-cycle pulse when period/highTime update
//   overflow     out  last measured period saturated the counter
//   timeout      out  sticky loss-of-clock flag
// Optional feature: define CLK_METER_TIMEOUT_EN to enable loss-of-clock
// detection; otherwise timeout is tied low and MEASURE persists.
// -----------------------------------------------------------------------------
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clkIn,
  input  logic             reset,
  input  logic             clkDiv,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] highTime,
  output logic             periodValid,
  output logic             overflow,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic div_level;
  logic div_rise;

  edge_sync u_edge_sync (
    .clkIn (clkIn),
    .reset (reset),
    .din   (clkDiv),
    .level (div_level),
    .rise  (div_rise)
  );

  meter_state_e     state_q,     state_d;
  logic [WIDTH-1:0] per_cnt_q,   per_cnt_d;
  logic [WIDTH-1:0] high_cnt_q,  high_cnt_d;
  logic [WIDTH-1:0] period_q,    period_d;
  logic [WIDTH-1:0] high_time_q, high_time_d;
  logic             valid_q,     valid_d;
  logic             ovf_q,       ovf_d;

`ifdef CLK_METER_TIMEOUT_EN
  // A TIMEOUT beyond the counter range can never be reached; the counter
  // just saturates in that case.
  localparam bit               TO_REACHABLE = (longint'(TIMEOUT) <= longint'(CNT_MAX));
  localparam logic [WIDTH-1:0] TO_LAST      = WIDTH'(TIMEOUT - 1);
  logic timeout_q, timeout_d;
`endif

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case/if tree leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    per_cnt_d   = per_cnt_q;
    high_cnt_d  = high_cnt_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = 1'b0;
    ovf_d       = ovf_q;
`ifdef CLK_METER_TIMEOUT_EN
    timeout_d   = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        per_cnt_d  = '0;
        high_cnt_d = '0;
        if (div_rise) begin
          state_d   = MEASURE;
          per_cnt_d = WIDTH'(1);
        end
      end
      MEASURE: begin
        if (div_rise) begin
          period_d    = per_cnt_q;
          high_time_d = high_cnt_q;
          valid_d     = 1'b1;
          ovf_d       = (per_cnt_q == CNT_MAX);
          per_cnt_d   = WIDTH'(1);
          high_cnt_d  = '0;
`ifdef CLK_METER_TIMEOUT_EN
          timeout_d   = 1'b0;
`endif
        end else begin
          if (per_cnt_q != CNT_MAX) per_cnt_d = per_cnt_q + WIDTH'(1);
          if (div_level && (high_cnt_q != CNT_MAX)) high_cnt_d = high_cnt_q + WIDTH'(1);
`ifdef CLK_METER_TIMEOUT_EN
          // Flag instead of counting to TIMEOUT; restart from a fresh first edge.
          if (TO_REACHABLE && (per_cnt_q == TO_LAST)) begin
            timeout_d  = 1'b1;
            state_d    = IDLE;
            per_cnt_d  = '0;
            high_cnt_d = '0;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkIn or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      per_cnt_q   <= '0;
      high_cnt_q  <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      ovf_q       <= 1'b0;
`ifdef CLK_METER_TIMEOUT_EN
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      per_cnt_q   <= per_cnt_d;
      high_cnt_q  <= high_cnt_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      ovf_q       <= ovf_d;
`ifdef CLK_METER_TIMEOUT_EN
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign period      = period_q;
  assign highTime    = high_time_q;
  assign periodValid = valid_q;
  assign overflow    = ovf_q;
`ifdef CLK_METER_TIMEOUT_EN
  assign timeout     = timeout_q;
`else
  assign timeout     = 1'b0;
`endif

endmodule : clk_period_meter

// File: tb/tb_clk_period_meter.sv
// -----------------------------------------------------------------------------
// tb_clk_period_meter
// Directed bench for clk_period_meter: a WIDTH=16 instance (main checks,
// TIMEOUT=50) and a WIDTH=4 instance (saturation/overflow). Each periodValid
// pulse is captured into a queue and compared with hand-computed values.
// -----------------------------------------------------------------------------
module tb_clk_period_meter;

  typedef struct {
    int p;
    int h;
    int o;
  } rec_t;

  logic        clk;
  logic        reset;
  logic        div16;
  logic        div4;
  logic [15:0] period16;
  logic [15:0] high16;
  logic        valid16, ovf16, to16;
  logic [3:0]  period4;
  logic [3:0]  high4;
  logic        valid4, ovf4, to4;

  int   checks   = 0;
  int   failures = 0;
  rec_t q16[$];
  rec_t q4[$];

  clk_period_meter #(.WIDTH(16), .TIMEOUT(50)) dut16 (
    .clkIn(clk), .reset(reset), .clkDiv(div16), .period(period16),
    .highTime(high16), .periodValid(valid16), .overflow(ovf16), .timeout(to16)
  );

  clk_period_meter #(.WIDTH(4), .TIMEOUT(50)) dut4 (
    .clkIn(clk), .reset(reset), .clkDiv(div4), .period(period4),
    .highTime(high4), .periodValid(valid4), .overflow(ovf4), .timeout(to4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every measurement pulse, sampled away from the active edge.
  always @(negedge clk) begin
    if (valid16) q16.push_back('{p: int'(period16), h: int'(high16), o: int'(ovf16)});
    if (valid4)  q4.push_back('{p: int'(period4),  h: int'(high4),  o: int'(ovf4)});
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive n periods of per cycles with hi cycles high; starts and ends on a negedge.
  task automatic drive(input int which, input int n, input int per, input int hi);
    for (int i = 0; i < n; i++) begin
      if (which == 0) div16 = 1'b1; else div4 = 1'b1;
      repeat (hi) @(negedge clk);
      if (which == 0) div16 = 1'b0; else div4 = 1'b0;
      repeat (per - hi) @(negedge clk);
    end
  endtask

  task automatic pop16(input string tag, input int ep, input int eh, input int eo);
    rec_t r;
    if (q16.size() == 0) begin
      check({tag, "_present"}, 0, 1);
    end else begin
      r = q16.pop_front();
      check({tag, "_period"}, r.p, ep);
      check({tag, "_high"}, r.h, eh);
      check({tag, "_ovf"}, r.o, eo);
    end
  endtask

  task automatic pop4(input string tag, input int ep, input int eh, input int eo);
    rec_t r;
    if (q4.size() == 0) begin
      check({tag, "_present"}, 0, 1);
    end else begin
      r = q4.pop_front();
      check({tag, "_period"}, r.p, ep);
      check({tag, "_high"}, r.h, eh);
      check({tag, "_ovf"}, r.o, eo);
    end
  endtask

  initial begin
    reset = 1'b1;
    div16 = 1'b0;
    div4  = 1'b0;

    // Reset state (checked mid-reset, on a negedge).
    #50;
    check("rst_period", int'(period16), 0);
    check("rst_high", int'(high16), 0);
    check("rst_valid", int'(valid16), 0);
    check("rst_ovf", int'(ovf16), 0);
    check("rst_timeout", int'(to16), 0);
    check("rst_period4", int'(period4), 0);
    #50;  // t=100, a negedge
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_no_pulse", q16.size(), 0);

    // Continuous stream: 10/5 x4, 7/2 x3, 10/5 x2, 12/6 x2.
    drive(0, 1, 10, 5);
    check("first_edge_no_pulse", q16.size(), 0);
    drive(0, 3, 10, 5);
    drive(0, 3, 7, 2);
    drive(0, 2, 10, 5);
    drive(0, 2, 12, 6);
    repeat (6) @(negedge clk);
    check("stream_count", q16.size(), 10);
    pop16("p10_a", 10, 5, 0);
    pop16("p10_b", 10, 5, 0);
    pop16("p10_c", 10, 5, 0);
    pop16("p10_to7", 10, 5, 0);
    pop16("p7_a", 7, 2, 0);
    pop16("p7_b", 7, 2, 0);
    pop16("p7_to10", 7, 2, 0);
    pop16("p10_d", 10, 5, 0);
    pop16("p10_to12", 10, 5, 0);
    pop16("p12", 12, 6, 0);
    check("stream_drained", q16.size(), 0);
    check("timeout_clear", int'(to16), 0);

    // Reset mid-period.
    check("pre_rst_period", int'(period16), 12);
    check("pre_rst_high", int'(high16), 6);
    div16 = 1'b1;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_period", int'(period16), 0);
    check("midrst_high", int'(high16), 0);
    check("midrst_valid", int'(valid16), 0);
    check("midrst_ovf", int'(ovf16), 0);
    check("midrst_timeout", int'(to16), 0);
    div16 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    q16.delete();
    drive(0, 1, 10, 5);
    check("postrst_first_no_pulse", q16.size(), 0);
    drive(0, 1, 10, 5);
    pop16("postrst_p10", 10, 5, 0);
    repeat (6) @(negedge clk);
    check("postrst_drained", q16.size(), 0);

    // clkDiv stopped after lock.
    repeat (70) @(negedge clk);
    check("stopped_no_pulse", q16.size(), 0);
`ifdef CLK_METER_TIMEOUT_EN
    check("timeout_set", int'(to16), 1);
    drive(0, 1, 10, 5);
    check("restart_first_no_pulse", q16.size(), 0);
    check("timeout_sticky", int'(to16), 1);
    drive(0, 1, 10, 5);
    pop16("restart_p10", 10, 5, 0);
    check("timeout_cleared", int'(to16), 0);
`else
    check("timeout_tied_low", int'(to16), 0);
`endif

    // WIDTH=4: period 20 saturates at 15, then 7 clears overflow.
    drive(1, 1, 20, 10);
    check("w4_first_no_pulse", q4.size(), 0);
    drive(1, 2, 20, 10);
    drive(1, 2, 7, 2);
    repeat (6) @(negedge clk);
    check("w4_count", q4.size(), 4);
    pop4("w4_sat_a", 15, 10, 1);
    pop4("w4_sat_b", 15, 10, 1);
    pop4("w4_sat_to7", 15, 10, 1);
    pop4("w4_p7", 7, 2, 0);
    check("w4_ovf_now", int'(ovf4), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_clk_period_meter
